mem_io_bridge: RTL and testbench

// - Sits directly downstream of the cpu memory port (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).
// - Decodes each bus cycle to the 128KB RAM or the I/O page (cpu_a[17:16]==2'b11).
// - Buffers UART TX bytes in a small FIFO and exposes the RX byte and a cycle counter.
// - Raises the program-stop flag.

---
 rtl/mem_io_bridge_pkg.sv | 27 ++
 rtl/mem_io_txq.sv | 54 +++++
 rtl/mem_io_bridge.sv | 140 ++++++++++++++
 tb/tb_mem_io_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_bridge_pkg.sv
// Shared constants for the cpu memory/IO bridge: I/O page decode,
// register addresses, and the read-return source select encoding.
package mem_io_bridge_pkg;

    localparam logic [1:0]  IO_PAGE   = 2'b11;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CNT  = 18'h30004;

    // Source of the byte returned on cpu_din one cycle after a read
    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_RX   = 2'd1,
        SEL_CNT  = 2'd2,
        SEL_ZERO = 2'd3
    } sel_e;

    // Pick byte idx out of a 32-bit word (little-endian byte numbering)
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_io_txq.sv
// Small synchronous FIFO for UART TX bytes. A push while full is accepted
// only when a pop happens in the same cycle; the caller detects drops.
module mem_io_txq #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       i_push,
    input  logic [7:0]                 i_din,
    input  logic                       i_pop,
    output logic [7:0]                 o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_dout    = r_mem[r_rp];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Storage: data only, contents are meaningless while empty
    always_ff @(posedge clk_in) begin
        if (w_push_ok) r_mem[r_wp] <= i_din;
    end

    // Pointers wrap naturally; count tracks occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + AW'(1);
            if (w_pop_ok)  r_rp <= r_rp + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the cpu memory port and the 128KB RAM / I/O page.
// Holds address decode, read-return select, cycle counter, RX latch,
// TX FIFO and the sticky stop/overflow flags.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int TXQ_DEPTH   = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_io_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    input  logic        uart_tx_full,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_ack,
    output logic        prog_done,
    output logic        tx_overflow
);
    localparam int AW = $clog2(TXQ_DEPTH);

    logic        w_io, w_acc, w_rd, w_wr;
    logic        w_uart_addr, w_cnt_addr, w_cnt_word;
    logic        w_rx_rd, w_push, w_pop, w_full, w_empty;
    logic [7:0]  w_push_data, w_head, w_din;
    logic [AW:0] w_count;
    sel_e        w_sel_d;
    logic        w_unused_hi;

    sel_e        r_sel;
    logic [1:0]  r_bidx;
    logic [7:0]  r_rx;
    logic [31:0] r_cyc, r_snap;
    logic        r_done, r_ovf, r_io_full;

    // Only the 18-bit physical address is decoded
    assign w_unused_hi = ^cpu_a[31:18];

    assign w_io        = (cpu_a[17:16] == IO_PAGE);
    assign w_acc       = rst_in & rdy_in;
    assign w_rd        = w_acc & ~cpu_wr;
    assign w_wr        = w_acc & cpu_wr;
    assign w_uart_addr = (cpu_a[17:0] == ADDR_UART);
    assign w_cnt_addr  = (cpu_a[17:0] == ADDR_CNT);
    assign w_cnt_word  = (cpu_a[17:2] == ADDR_CNT[17:2]);
    assign w_rx_rd     = w_rd & w_uart_addr;

    // RAM side is a straight pass-through, held at 0 while in reset
    assign ram_a       = rst_in ? cpu_a[16:0] : '0;
    assign ram_wdata   = rst_in ? cpu_dout : '0;
    assign ram_we      = w_wr & ~w_io;
    assign uart_rx_ack = w_rx_rd & uart_rx_valid;

    // Zero bytes to the UART are dropped; a stop write queues a terminator
    assign w_push      = w_wr & ((w_uart_addr & (cpu_dout != 8'h00)) | w_cnt_addr);
    assign w_push_data = w_cnt_addr ? 8'h00 : cpu_dout;
    assign w_pop       = ~w_empty & ~uart_tx_full;

    assign uart_tx_en   = w_pop;
    assign uart_tx_data = w_pop ? w_head : 8'h00;
    assign prog_done    = r_done;
    assign tx_overflow  = r_ovf;
    assign cpu_io_full  = r_io_full;

    mem_io_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Decode where the next read-return byte comes from
    always_comb begin
        w_sel_d = SEL_ZERO;
        if (!w_io)            w_sel_d = SEL_RAM;
        else if (w_uart_addr) w_sel_d = SEL_RX;
        else if (w_cnt_word)  w_sel_d = SEL_CNT;
    end

    // Read-return mux; RAM data arrives one cycle after the address
    always_comb begin
        w_din = 8'h00;
        case (r_sel)
            SEL_RAM: w_din = ram_rdata;
            SEL_RX:  w_din = r_rx;
            SEL_CNT: w_din = byte_of(r_snap, r_bidx);
            default: w_din = 8'h00;
        endcase
        cpu_din = rst_in ? w_din : 8'h00;
    end

    // Read-select, RX latch and counter snapshot, updated on accepted reads
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sel  <= SEL_RAM;
            r_bidx <= 2'd0;
            r_rx   <= 8'h00;
            r_snap <= '0;
        end else begin
            if (w_rd) begin
                r_sel  <= w_sel_d;
                r_bidx <= cpu_a[1:0];
            end
            if (w_rx_rd)            r_rx   <= uart_rx_valid ? uart_rx_data : 8'h00;
            if (w_rd && w_cnt_addr) r_snap <= r_cyc;
        end
    end

    // Free-running cycle counter, sticky flags and the registered full view
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cyc     <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_io_full <= 1'b0;
        end else begin
            r_cyc     <= r_cyc + 32'd1;
            if (w_wr && w_cnt_addr)           r_done <= 1'b1;
            if (w_push && w_full && !w_pop)   r_ovf  <= 1'b1;
            r_io_full <= ((TXQ_DEPTH - int'(w_count)) <= FULL_MARGIN);
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: stimulus pushes expected read-return
// and TX bytes into queues, a negedge monitor pops and compares them.
module tb_mem_io_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        cpu_io_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = 8'h00;
    logic        uart_tx_full = 1'b0;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_ack;
    logic        prog_done;
    logic        tx_overflow;

    int checks = 0;
    int failures = 0;
    int n_tx = 0;
    int n_ack = 0;
    logic [7:0]  rd_exp[$];
    logic [7:0]  tx_exp[$];
    logic        rd_pend = 1'b0;
    logic [31:0] tb_cyc = '0;
    logic [7:0]  mem [0:131071];

    always #5 clk_in = ~clk_in;

    mem_io_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
        .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .cpu_io_full(cpu_io_full), .ram_a(ram_a), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .uart_tx_full(uart_tx_full),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .uart_rx_ack(uart_rx_ack), .prog_done(prog_done), .tx_overflow(tx_overflow)
    );

    // External RAM with 1-cycle read latency
    always @(posedge clk_in) begin
        if (ram_we) mem[ram_a] <= ram_wdata;
        ram_rdata <= mem[ram_a];
    end

    // Reference cycle count and read-in-flight tracking
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tb_cyc  <= '0;
            rd_pend <= 1'b0;
        end else begin
            tb_cyc  <= tb_cyc + 32'd1;
            rd_pend <= rdy_in & ~cpu_wr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queues
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (rd_pend) begin
                chk("rd_expected", 32'(rd_exp.size() != 0), 32'd1);
                if (rd_exp.size() != 0) chk("cpu_din", {24'd0, cpu_din}, {24'd0, rd_exp.pop_front()});
            end
            if (uart_tx_en) begin
                n_tx++;
                chk("tx_expected", 32'(tx_exp.size() != 0), 32'd1);
                if (tx_exp.size() != 0) chk("uart_tx_data", {24'd0, uart_tx_data}, {24'd0, tx_exp.pop_front()});
            end
            if (uart_rx_ack) n_ack++;
        end
    end

    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
        @(posedge clk_in); #1;
        rdy_in = 1'b1; cpu_wr = wr; cpu_a = a; cpu_dout = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in); #1;
            rdy_in = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_dout = '0;
        end
    endtask

    initial begin
        logic [31:0] snap_n;
        int n_tx0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_cpu_din", {24'd0, cpu_din}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_tx_en", {31'd0, uart_tx_en}, 32'd0);
        chk("rst_prog_done", {31'd0, prog_done}, 32'd0);
        chk("rst_tx_overflow", {31'd0, tx_overflow}, 32'd0);
        chk("rst_io_full", {31'd0, cpu_io_full}, 32'd0);
        @(negedge clk_in) rst_in = 1'b1;

        // RAM write/read, incl. top of RAM
        bus(1'b1, 32'h0000_0100, 8'h5A);
        #2;
        chk("ram_we_wr", {31'd0, ram_we}, 32'd1);
        chk("ram_a_wr", {15'd0, ram_a}, 32'h100);
        chk("ram_wdata_wr", {24'd0, ram_wdata}, 32'h5A);
        bus(1'b0, 32'h0000_0100, 8'h00); rd_exp.push_back(8'h5A);
        #2 chk("ram_we_rd", {31'd0, ram_we}, 32'd0);
        bus(1'b1, 32'h0001_FFFF, 8'hC3);
        bus(1'b0, 32'h0001_FFFF, 8'h00); rd_exp.push_back(8'hC3);
        idle(2);

        // TX path: two bytes drained in order, zero byte ignored
        tx_exp.push_back(8'h48);
        bus(1'b1, 32'h0003_0000, 8'h48);
        #2 chk("ram_we_io", {31'd0, ram_we}, 32'd0);
        tx_exp.push_back(8'h69);
        bus(1'b1, 32'h0003_0000, 8'h69);
        bus(1'b1, 32'h0003_0000, 8'h00);
        idle(4);
        chk("tx_count_hi", n_tx, 32'd2);

        // Backpressure: fill, watch io_full and overflow, then drain
        uart_tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_exp.push_back(8'h10 + 8'(i));
            bus(1'b1, 32'h0003_0000, 8'h10 + 8'(i));
        end
        idle(2);
        chk("io_full_at5", {31'd0, cpu_io_full}, 32'd0);
        tx_exp.push_back(8'h15); bus(1'b1, 32'h0003_0000, 8'h15);
        idle(2);
        chk("io_full_at6", {31'd0, cpu_io_full}, 32'd1);
        tx_exp.push_back(8'h16); bus(1'b1, 32'h0003_0000, 8'h16);
        tx_exp.push_back(8'h17); bus(1'b1, 32'h0003_0000, 8'h17);
        idle(1);
        chk("ovf_at8", {31'd0, tx_overflow}, 32'd0);
        bus(1'b1, 32'h0003_0000, 8'h18);
        idle(1);
        chk("ovf_at9", {31'd0, tx_overflow}, 32'd1);
        uart_tx_full = 1'b0;
        idle(12);
        chk("drain_left", tx_exp.size(), 32'd0);
        chk("tx_count_drain", n_tx, 32'd10);
        chk("io_full_drained", {31'd0, cpu_io_full}, 32'd0);

        // Counter snapshot and byte reassembly; out-of-range I/O reads 0
        bus(1'b0, 32'h0003_0004, 8'h00);
        snap_n = tb_cyc;
        rd_exp.push_back(snap_n[7:0]);
        bus(1'b0, 32'h0003_0005, 8'h00); rd_exp.push_back(snap_n[15:8]);
        bus(1'b0, 32'h0003_0006, 8'h00); rd_exp.push_back(snap_n[23:16]);
        bus(1'b0, 32'h0003_0007, 8'h00); rd_exp.push_back(snap_n[31:24]);
        bus(1'b0, 32'h0003_0008, 8'h00); rd_exp.push_back(8'h00);
        idle(2);

        // RX latch with and without a valid byte
        uart_rx_valid = 1'b1; uart_rx_data = 8'h41;
        bus(1'b0, 32'h0003_0000, 8'h00); rd_exp.push_back(8'h41);
        #2 chk("rx_ack_valid", {31'd0, uart_rx_ack}, 32'd1);
        idle(2);
        uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
        bus(1'b0, 32'h0003_0000, 8'h00); rd_exp.push_back(8'h00);
        #2 chk("rx_ack_none", {31'd0, uart_rx_ack}, 32'd0);
        idle(2);
        chk("rx_ack_count", n_ack, 32'd1);

        // rdy_in low: no push, no stop, no RAM write
        @(posedge clk_in); #1;
        rdy_in = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h0003_0004; cpu_dout = 8'h77;
        #2 chk("ram_we_nordy", {31'd0, ram_we}, 32'd0);
        idle(3);
        chk("prog_done_nordy", {31'd0, prog_done}, 32'd0);

        // Stop write emits a terminator and sets sticky prog_done
        tx_exp.push_back(8'h00);
        bus(1'b1, 32'h0003_0004, 8'h99);
        idle(3);
        chk("prog_done_set", {31'd0, prog_done}, 32'd1);
        tx_exp.push_back(8'h00);
        bus(1'b1, 32'h0003_0004, 8'h01);
        idle(3);
        chk("prog_done_sticky", {31'd0, prog_done}, 32'd1);
        chk("tx_count_stop", n_tx, 32'd12);

        // Reset in the middle of a drain
        uart_tx_full = 1'b1;
        tx_exp.push_back(8'hA1); bus(1'b1, 32'h0003_0000, 8'hA1);
        tx_exp.push_back(8'hA2); bus(1'b1, 32'h0003_0000, 8'hA2);
        tx_exp.push_back(8'hA3); bus(1'b1, 32'h0003_0000, 8'hA3);
        bus(1'b0, 32'h0000_0100, 8'h00);
        uart_tx_full = 1'b0;
        @(posedge clk_in); #3;
        rst_in = 1'b0;
        #1;
        chk("mid_rst_tx_en", {31'd0, uart_tx_en}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
        chk("mid_rst_cpu_din", {24'd0, cpu_din}, 32'd0);
        chk("mid_rst_prog_done", {31'd0, prog_done}, 32'd0);
        chk("mid_rst_ovf", {31'd0, tx_overflow}, 32'd0);
        chk("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("mid_rst_left", tx_exp.size(), 32'd2);
        tx_exp.delete();
        rd_exp.delete();
        rdy_in = 1'b0; cpu_wr = 1'b0; cpu_a = '0;
        n_tx0 = n_tx;
        @(negedge clk_in) rst_in = 1'b1;
        idle(6);
        chk("post_rst_no_tx", n_tx, n_tx0);
        chk("post_rst_io_full", {31'd0, cpu_io_full}, 32'd0);
        chk("rd_left", rd_exp.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
